reg_write_ctrl: RTL and testbench

- Write-side controller for the 16 x 8-bit CPU register file; it is the only block that drives the file's WRITE, INADDRESS and IN inputs.
- Accepts write-back requests from two sources, ALU results and memory-load data, through valid/ready handshakes. Requests are buffered in a small FIFO and retired at one register write per clock.
- After reset, and on demand, it runs a clear sequence that zeroes every register. This gives a full, deterministic register-file initialisation.

---
 rtl/reg_write_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_reg_write_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_ctrl.sv
// ---------------------------------------------------------------------------
// reg_write_ctrl
//
// Write-side controller for the 16 x 8-bit CPU register file. It is the only
// driver of the file's WRITE / INADDRESS / IN inputs. After reset, or when
// CLEAR is pulsed, it zeroes every register, one register per clock. Outside
// that sequence it accepts write-back requests from the ALU and from the load
// path. Requests are buffered in a small FIFO and retired at one write per
// clock, in strict acceptance order.
//
// Optional feature (macro REG_WRITE_CTRL_FWD_EN): a combinational lookup port
// (QADDR -> QHIT/QDATA). It returns the youngest pending value for an
// address, taken from the FIFO or from the output register.
//
// Ports:
//   CLK        clock, all state updates on the posedge
//   RESET      asynchronous active-low reset
//   CLEAR      single-cycle request to restart the clear sequence
//   ALU_VALID/ALU_ADDR/ALU_DATA/ALU_READY   ALU write-back request
//   LD_VALID/LD_ADDR/LD_DATA/LD_READY       load write-back request
//   WRITE/INADDRESS/IN   registered register-file write port
//   BUSY       high while the clear sequence runs; it mirrors the FSM state
//   QADDR/QHIT/QDATA     forwarding lookup (only with REG_WRITE_CTRL_FWD_EN)
//
// Handshake: a request transfers on a clock edge where VALID && READY.
// READY is combinational and does not depend on the requester's own VALID.
// LD_VALID does gate ALU_READY, because loads win a same-cycle conflict.
// At most one push happens per cycle.
// ---------------------------------------------------------------------------
module reg_write_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 16,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLEAR,
    input  logic              ALU_VALID,
    input  logic [ADDR_W-1:0] ALU_ADDR,
    input  logic [DATA_W-1:0] ALU_DATA,
    output logic              ALU_READY,
    input  logic              LD_VALID,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic              LD_READY,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN,
    output logic              BUSY
`ifdef REG_WRITE_CTRL_FWD_EN
    ,
    input  logic [ADDR_W-1:0] QADDR,
    output logic              QHIT,
    output logic [DATA_W-1:0] QDATA
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic              run;
    logic              full;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;

    assign BUSY = (state == S_CLEAR);

    // Readiness looks only at the registered count. A pop in the same cycle
    // does not free a slot for the push, which keeps READY off the pop path.
    always_comb begin
        run       = (state == S_RUN);
        full      = (count == CNT_W'(DEPTH));
        LD_READY  = run && !full;
        ALU_READY = run && !full && !LD_VALID;
        push      = (LD_VALID && LD_READY) || (ALU_VALID && ALU_READY);
        push_addr = LD_VALID ? LD_ADDR : ALU_ADDR;
        push_data = LD_VALID ? LD_DATA : ALU_DATA;
        // A CLEAR in S_RUN discards the queue, so nothing retires on that edge.
        pop       = run && !CLEAR && (count != '0);
    end

    // FIFO storage has no reset. Validity is tracked by count and the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_CLEAR;
            clr_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (CLEAR) begin
                        // Restart: this edge writes nothing. The sequence
                        // then begins again from register 0.
                        clr_cnt <= '0;
                        WRITE   <= 1'b0;
                    end else begin
                        WRITE     <= 1'b1;
                        INADDRESS <= clr_cnt;
                        IN        <= '0;
                        if (clr_cnt == LAST_REG) begin
                            clr_cnt <= '0;
                            state   <= S_RUN;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (CLEAR) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                        WRITE   <= 1'b0;
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        count   <= '0;
                    end else begin
                        WRITE <= pop;
                        if (pop) begin
                            INADDRESS <= mem_addr[rd_ptr];
                            IN        <= mem_data[rd_ptr];
                            rd_ptr    <= rd_ptr + 1'b1;
                        end
                        if (push) begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                        case ({push, pop})
                            2'b10:   count <= count + 1'b1;
                            2'b01:   count <= count - 1'b1;
                            default: count <= count;
                        endcase
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

`ifdef REG_WRITE_CTRL_FWD_EN
    // The output register is the oldest candidate. The FIFO is walked from
    // oldest to newest, and each later match overrides an earlier one, so
    // the youngest value wins.
    always_comb begin
        QHIT  = 1'b0;
        QDATA = '0;
        if (state == S_RUN) begin
            if (WRITE && (INADDRESS == QADDR)) begin
                QHIT  = 1'b1;
                QDATA = IN;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CNT_W'(i) < count) &&
                    (mem_addr[rd_ptr + PTR_W'(i)] == QADDR)) begin
                    QHIT  = 1'b1;
                    QDATA = mem_data[rd_ptr + PTR_W'(i)];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_write_ctrl
//
// Cycle-level reference model of the write controller. Inputs are driven on
// the negedge. READY (and the forwarding lookup, when built) is compared
// before the posedge. The register-file write port and BUSY are compared
// #1 after the posedge. Accepted requests go into exp_q in acceptance order,
// and the model pops the head on each edge where a retire is due.
// ---------------------------------------------------------------------------
module tb_reg_write_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              write;
    logic [ADDR_W-1:0] inaddress;
    logic [DATA_W-1:0] in_data;
    logic              busy;
`ifdef REG_WRITE_CTRL_FWD_EN
    logic [ADDR_W-1:0] qaddr;
    logic              qhit;
    logic [DATA_W-1:0] qdata;
`endif

    reg_write_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .DEPTH(DEPTH)
    ) dut (
        .CLK(clk), .RESET(rst_n), .CLEAR(clear),
        .ALU_VALID(alu_valid), .ALU_ADDR(alu_addr), .ALU_DATA(alu_data),
        .ALU_READY(alu_ready),
        .LD_VALID(ld_valid), .LD_ADDR(ld_addr), .LD_DATA(ld_data),
        .LD_READY(ld_ready),
        .WRITE(write), .INADDRESS(inaddress), .IN(in_data), .BUSY(busy)
`ifdef REG_WRITE_CTRL_FWD_EN
        , .QADDR(qaddr), .QHIT(qhit), .QDATA(qdata)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    bit                m_run;
    int                m_cnt;
    bit                exp_w;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        clear     = 1'b0;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_run    = 1'b0;
        m_cnt    = 0;
        exp_w    = 1'b0;
        exp_addr = '0;
        exp_data = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_write"}, write, 0);
        check({tag, "_inaddr"}, inaddress, 0);
        check({tag, "_in"}, in_data, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ld_rdy"}, ld_ready, 0);
        check({tag, "_alu_rdy"}, alu_ready, 0);
    endtask

    // One clock. The caller has set the inputs on the negedge; the task
    // returns on the following negedge.
    task automatic cycle();
        bit                       e_full, e_ld_rdy, e_alu_rdy;
        logic [ADDR_W+DATA_W-1:0] e;
        #1;
        e_full    = (exp_q.size() == DEPTH);
        e_ld_rdy  = m_run && !e_full;
        e_alu_rdy = e_ld_rdy && !ld_valid;
        check("ld_ready", ld_ready, e_ld_rdy);
        check("alu_ready", alu_ready, e_alu_rdy);
`ifdef REG_WRITE_CTRL_FWD_EN
        begin
            bit                e_hit;
            logic [DATA_W-1:0] e_dat;
            e_hit = 1'b0;
            e_dat = '0;
            if (m_run) begin
                if (exp_w && exp_addr == qaddr) begin
                    e_hit = 1'b1;
                    e_dat = exp_data;
                end
                foreach (exp_q[i]) begin
                    if (exp_q[i][ADDR_W+DATA_W-1:DATA_W] == qaddr) begin
                        e_hit = 1'b1;
                        e_dat = exp_q[i][DATA_W-1:0];
                    end
                end
            end
            check("qhit", qhit, e_hit);
            check("qdata", qdata, e_dat);
        end
`endif
        if (!m_run) begin
            if (clear) begin
                m_cnt = 0;
                exp_w = 1'b0;
            end else begin
                exp_w    = 1'b1;
                exp_addr = m_cnt[ADDR_W-1:0];
                exp_data = '0;
                m_cnt++;
                if (m_cnt == NREGS) begin
                    m_run = 1'b1;
                    m_cnt = 0;
                end
            end
        end else if (clear) begin
            exp_q.delete();
            m_run = 1'b0;
            m_cnt = 0;
            exp_w = 1'b0;
        end else begin
            exp_w = (exp_q.size() > 0);
            if (exp_w) begin
                e        = exp_q.pop_front();
                exp_addr = e[ADDR_W+DATA_W-1:DATA_W];
                exp_data = e[DATA_W-1:0];
            end
            if (ld_valid && e_ld_rdy)
                exp_q.push_back({ld_addr, ld_data});
            else if (alu_valid && e_alu_rdy)
                exp_q.push_back({alu_addr, alu_data});
        end
        @(posedge clk);
        #1;
        check("write", write, exp_w);
        check("inaddress", inaddress, exp_addr);
        check("in", in_data, exp_data);
        check("busy", busy, !m_run);
        @(negedge clk);
    endtask

    task automatic drive_alu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        alu_valid = 1'b1;
        alu_addr  = a;
        alu_data  = d;
    endtask

    task automatic drive_ld(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            cycle();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        alu_addr = '0;
        alu_data = '0;
        ld_addr  = '0;
        ld_data  = '0;
`ifdef REG_WRITE_CTRL_FWD_EN
        qaddr = '0;
`endif
        idle_inputs();
        model_reset();
        #1;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Power-up clear: 16 zero writes, then two idle cycles in S_RUN.
        idle_cycles(NREGS + 2);

        // Single ALU request.
        drive_alu(4'd3, 8'h5A);
        cycle();
        idle_cycles(3);

        // Load and ALU together: the load wins, and the ALU holds until it
        // is accepted.
        drive_ld(4'd1, 8'h11);
        drive_alu(4'd2, 8'h22);
        cycle();
        ld_valid = 1'b0;
        cycle();
        idle_cycles(3);

        // Five back-to-back requests.
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            drive_alu(4'(i + 8), 8'(8'hA0 + i));
            cycle();
        end
        idle_cycles(3);

        // CLEAR while a request is pending. That request must never be written.
        drive_ld(4'd7, 8'h77);
        cycle();
        idle_inputs();
        drive_alu(4'd9, 8'h99);
        cycle();
        idle_inputs();
        clear = 1'b1;
        cycle();
        idle_cycles(NREGS + 2);

        // Same address twice. The lookup must return the younger value.
        drive_alu(4'd5, 8'h10);
        cycle();
        idle_inputs();
        drive_alu(4'd5, 8'h20);
`ifdef REG_WRITE_CTRL_FWD_EN
        qaddr = 4'd5;
`endif
        cycle();
        idle_inputs();
        cycle();
        idle_cycles(2);

        // Random traffic. CLEAR is raised only in S_RUN.
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            if ($urandom_range(1, 0) == 1) drive_ld(4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)));
            if ($urandom_range(1, 0) == 1) drive_alu(4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)));
            if (m_run && $urandom_range(39, 0) == 0) clear = 1'b1;
`ifdef REG_WRITE_CTRL_FWD_EN
            qaddr = 4'($urandom_range(15, 0));
`endif
            cycle();
        end
        idle_cycles(3);

        // Asynchronous reset partway through a clear sequence.
        clear = 1'b1;
        cycle();
        idle_cycles(5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(NREGS + 2);
        drive_ld(4'd14, 8'hEE);
        cycle();
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
